// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side signals of the shared UART transmitter arbiter.
// The arbiter uses the slave modport; requesters plus the UART TX model the master side.
interface uart_tx_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           transmit;
    logic [7:0]     TX_DATA;
    logic           busy;
    logic [2:0]     grant_id;
    logic           active;
    logic           timeout_err;

    modport master (
        output req_valid, req_data, req_last, busy,
        input  req_ready, transmit, TX_DATA, grant_id, active, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, busy,
        output req_ready, transmit, TX_DATA, grant_id, active, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N byte requesters, with an
// optional burst lock that keeps a multi-byte message from being interleaved.
module uart_tx_arbiter #(
    parameter int N             = 4,
    parameter int MAX_BURST     = 16,
    parameter int START_TIMEOUT = 8191
) (
    input  logic             CLK,
    input  logic             RST,
    uart_tx_arbiter_if.slave bus
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } state_t;

    state_t        state_r, state_nx_s;
    logic [2:0]    ptr_r, grant_id_r, winner_s;
    logic          lock_r, lock_nx_s;
    logic [BW-1:0] burst_r, burst_nx_s, burst_eff_s;
    logic [TW-1:0] tcnt_r, tcnt_nx_s;
    logic [7:0]    tx_data_r;
    logic          transmit_r, active_r, timeout_r;
    logic          grant_s, timeout_s;
    logic [7:0]    valid_pad_s, last_pad_s, ready_pad_s;
    logic [63:0]   data_pad_s;
    logic [3:0]    cand_s;

    // Requester vectors widened to the 8-requester maximum so a 3-bit index is always in range
    assign valid_pad_s = 8'(bus.req_valid);
    assign last_pad_s  = 8'(bus.req_last);
    assign data_pad_s  = 64'(bus.req_data);

    // Next state, round-robin winner and burst-lock / start-timeout bookkeeping
    always_comb begin
        state_nx_s  = state_r;
        lock_nx_s   = lock_r;
        burst_nx_s  = burst_r;
        tcnt_nx_s   = tcnt_r;
        grant_s     = 1'b0;
        winner_s    = ptr_r;
        timeout_s   = 1'b0;
        burst_eff_s = burst_r;
        cand_s      = 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (RST || bus.busy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    if (lock_r && valid_pad_s[ptr_r]) begin
                        grant_s  = 1'b1;
                        winner_s = ptr_r;
                    end else begin
                        lock_nx_s   = 1'b0;
                        burst_nx_s  = '0;
                        burst_eff_s = '0;
                        // Walk from farthest to nearest so the first valid requester after ptr_r wins
                        for (int k = N; k >= 1; k--) begin
                            cand_s   = {1'b0, ptr_r} + 4'(k);
                            cand_s   = (cand_s >= 4'(N)) ? (cand_s - 4'(N)) : cand_s;
                            grant_s  = grant_s | valid_pad_s[cand_s[2:0]];
                            winner_s = valid_pad_s[cand_s[2:0]] ? cand_s[2:0] : winner_s;
                        end
                    end
                    if (grant_s) begin
                        state_nx_s = ST_ISSUE;
                        if (!last_pad_s[winner_s] &&
                            ((32'(burst_eff_s) + 32'd1) < 32'(MAX_BURST))) begin
                            lock_nx_s  = 1'b1;
                            burst_nx_s = burst_eff_s + BW'(1);
                        end else begin
                            lock_nx_s  = 1'b0;
                            burst_nx_s = '0;
                        end
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                state_nx_s = ST_WAIT_START;
                tcnt_nx_s  = '0;
            end
            ST_WAIT_START: begin
                if (bus.busy) begin
                    state_nx_s = ST_WAIT_DONE;
                end else if ((32'(tcnt_r) + 32'd1) >= 32'(START_TIMEOUT)) begin
                    state_nx_s = ST_IDLE;
                    timeout_s  = 1'b1;
                    lock_nx_s  = 1'b0;
                    burst_nx_s = '0;
                    tcnt_nx_s  = '0;
                end else begin
                    tcnt_nx_s = tcnt_r + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.busy) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                lock_nx_s  = 1'b0;
                burst_nx_s = '0;
                tcnt_nx_s  = '0;
            end
        endcase
    end

    // One-hot acceptance strobe, combinational so the byte is taken in the cycle it is seen
    assign ready_pad_s   = grant_s ? (8'd1 << winner_s) : 8'd0;
    assign bus.req_ready = ready_pad_s[N-1:0];

    // State and registered outputs; RST aborts any byte in flight without re-issuing it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 3'(N - 1);
            grant_id_r <= 3'd0;
            lock_r     <= 1'b0;
            burst_r    <= '0;
            tcnt_r     <= '0;
            tx_data_r  <= 8'd0;
            transmit_r <= 1'b0;
            active_r   <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            lock_r     <= lock_nx_s;
            burst_r    <= burst_nx_s;
            tcnt_r     <= tcnt_nx_s;
            transmit_r <= (state_nx_s == ST_ISSUE);
            active_r   <= (state_nx_s != ST_IDLE);
            timeout_r  <= timeout_s;
            if (grant_s) begin
                ptr_r      <= winner_s;
                grant_id_r <= winner_s;
                tx_data_r  <= data_pad_s[{winner_s, 3'b000} +: 8];
            end
        end
    end

    assign bus.transmit    = transmit_r;
    assign bus.TX_DATA     = tx_data_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.active      = active_r;
    assign bus.timeout_err = timeout_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter: requester queues and a UART
// model drive the DUT; a transaction-level model predicts every output each cycle.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 16;
    localparam int ST = 8191;

    logic CLK = 1'b0;
    logic RST;
    uart_tx_arbiter_if #(.N(N)) bus ();

    uart_tx_arbiter #(.N(N), .MAX_BURST(MB), .START_TIMEOUT(ST)) dut (
        .CLK(CLK), .RST(RST), .bus(bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [8:0] q [N][$];
    int vprob = 100;
    bit glitch_en = 1'b0;
    int drop_cnt = 0;
    int u_start = 0;
    int u_end = 0;
    int u_len_fixed = 0;
    bit rst_req = 1'b0;

    // reference model: one byte in flight, described by event timestamps
    bit         m_inflight = 1'b0;
    int         m_acc = -10;
    int         m_rise = -1;
    int         m_to = -1;
    bit         m_lock = 1'b0;
    int         m_cnt = 0;
    int         m_rr = N - 1;
    logic [2:0] m_gid = 3'd0;
    logic [7:0] m_txd = 8'd0;

    logic [7:0] mlog[$];
    logic [7:0] dlog[$];
    int d_tx_cnt, d_first_acc, d_first_tx, d_last_acc, d_to_cyc, e_first_tx, e_to_cyc;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit queues_busy();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r = r | (q[i].size() > 0);
        return r;
    endfunction

    task automatic cycle();
        logic [N-1:0]   v, l, exp_ready;
        logic [8*N-1:0] d;
        logic [8:0]     h;
        logic           b;
        bit             exp_tx, exp_act, exp_to;
        int             win, dly, len, j;
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && $urandom_range(99) < vprob) begin
                h = q[i][0];
                v[i] = 1'b1;
                d[8*i +: 8] = h[7:0];
                l[i] = h[8];
            end else begin
                v[i] = 1'b0;
                d[8*i +: 8] = 8'($urandom);
                l[i] = 1'($urandom);
            end
        end
        b = (cyc >= u_start) && (cyc < u_end);
        RST = rst_req;
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.busy      = b;
        @(negedge CLK);

        exp_tx  = m_inflight && (cyc == m_acc + 1);
        exp_act = m_inflight;
        exp_to  = (cyc == m_to);
        exp_ready = '0;
        win = -1;
        if (!rst_req && !m_inflight && !b) begin
            if (m_lock && v[m_rr]) begin
                win = m_rr;
            end else begin
                m_lock = 1'b0;
                m_cnt  = 0;
                for (int k = 1; k <= N; k++) begin
                    j = (m_rr + k) % N;
                    if (win < 0 && v[j]) win = j;
                end
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;

        check("req_ready",   32'(bus.req_ready),   32'(exp_ready));
        check("transmit",    32'(bus.transmit),    32'(exp_tx));
        check("TX_DATA",     32'(bus.TX_DATA),     32'(m_txd));
        check("grant_id",    32'(bus.grant_id),    32'(m_gid));
        check("active",      32'(bus.active),      32'(exp_act));
        check("timeout_err", 32'(bus.timeout_err), 32'(exp_to));

        if (bus.transmit) begin
            dlog.push_back(bus.TX_DATA);
            d_tx_cnt++;
            if (d_first_tx < 0) d_first_tx = cyc;
        end
        if (bus.req_ready != '0) begin
            if (d_first_acc < 0) d_first_acc = cyc;
            d_last_acc = cyc;
        end
        if (bus.timeout_err) d_to_cyc = cyc;
        if (exp_to) e_to_cyc = cyc;

        // UART model reacts to the predicted start pulse
        if (exp_tx) begin
            mlog.push_back(m_txd);
            if (e_first_tx < 0) e_first_tx = cyc;
            if (drop_cnt > 0) begin
                drop_cnt--;
            end else begin
                dly = $urandom_range(1, 3);
                len = (u_len_fixed > 0) ? u_len_fixed : $urandom_range(1, 6);
                u_start = cyc + dly;
                u_end = u_start + len;
            end
        end else if (glitch_en && !m_inflight && win < 0 && !b && $urandom_range(99) < 3) begin
            u_start = cyc + 1;
            u_end = cyc + 1 + $urandom_range(1, 4);
        end

        if (rst_req) begin
            m_inflight = 1'b0; m_lock = 1'b0; m_cnt = 0; m_rr = N - 1;
            m_gid = 3'd0; m_txd = 8'd0; m_to = -1;
        end else if (win >= 0) begin
            m_txd = d[8*win +: 8];
            m_gid = 3'(win);
            m_rr  = win;
            if (!l[win] && (m_cnt + 1) < MB) begin
                m_lock = 1'b1;
                m_cnt++;
            end else begin
                m_lock = 1'b0;
                m_cnt = 0;
            end
            m_inflight = 1'b1;
            m_acc = cyc;
            m_rise = -1;
            void'(q[win].pop_front());
        end else if (m_inflight && cyc >= m_acc + 2) begin
            if (m_rise < 0) begin
                if (b) begin
                    m_rise = cyc;
                end else if (cyc - m_acc - 1 == ST) begin
                    m_inflight = 1'b0;
                    m_to = cyc + 1;
                    m_lock = 1'b0;
                    m_cnt = 0;
                end
            end else if (!b) begin
                m_inflight = 1'b0;
            end
        end
    endtask

    task automatic drain(int max_cyc);
        int k = 0;
        while (k < max_cyc && (queues_busy() || m_inflight || cyc < u_end)) begin
            cycle();
            k++;
        end
        check("drain_bound", 32'(k < max_cyc), 32'd1);
        cycle();
        cycle();
    endtask

    task automatic begin_test();
        for (int i = 0; i < N; i++) q[i].delete();
        vprob = 100; glitch_en = 1'b0; drop_cnt = 0; u_len_fixed = 0;
        u_start = 0; u_end = 0;
        rst_req = 1'b1;
        cycle();
        cycle();
        rst_req = 1'b0;
        mlog.delete(); dlog.delete();
        d_tx_cnt = 0; d_first_acc = -1; d_first_tx = -1; d_last_acc = -1;
        d_to_cyc = -1; e_first_tx = -1; e_to_cyc = -1;
    endtask

    task automatic check_log(string name, logic [7:0] exp_q[$]);
        check({name, "_dut_len"}, 32'(dlog.size()), 32'(exp_q.size()));
        check({name, "_model_len"}, 32'(mlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check({name, "_dut_byte"}, 32'((i < dlog.size()) ? dlog[i] : 8'hxx), 32'(exp_q[i]));
            check({name, "_model_byte"}, 32'((i < mlog.size()) ? mlog[i] : 8'hxx), 32'(exp_q[i]));
        end
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int s, k, busy_end, r, len;
        RST = 1'b1;
        bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0; bus.busy = 1'b0;

        // single byte: accept in the cycle it is seen, pulse one cycle later
        begin_test();
        s = cyc + 1;
        q[0].push_back({1'b1, 8'h55});
        drain(200);
        check("t1_accept_cycle", 32'(d_first_acc), 32'(s));
        check("t1_tx_latency", 32'(d_first_tx - d_first_acc), 32'd1);
        check("t1_grant_id", 32'(bus.grant_id), 32'd0);
        check("t1_tx_data_held", 32'(bus.TX_DATA), 32'h55);
        exp_q = '{8'h55};
        check_log("t1_log", exp_q);

        // all four valid, strict rotation
        begin_test();
        for (int rr = 0; rr < 2; rr++)
            for (int i = 0; i < N; i++) q[i].push_back({1'b1, 8'hA0 + 8'(i)});
        drain(500);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        check_log("t2_log", exp_q);

        // three-byte message from req 2 stays contiguous
        begin_test();
        q[0].push_back({1'b1, 8'h01}); q[0].push_back({1'b1, 8'h02});
        q[1].push_back({1'b1, 8'h11}); q[1].push_back({1'b1, 8'h12});
        q[2].push_back({1'b0, 8'h21}); q[2].push_back({1'b0, 8'h22}); q[2].push_back({1'b1, 8'h23});
        drain(500);
        exp_q = '{8'h01, 8'h11, 8'h21, 8'h22, 8'h23, 8'h02, 8'h12};
        check_log("t3_log", exp_q);

        // burst limit: 16 locked bytes, then another requester gets a turn
        begin_test();
        for (int i = 0; i < 20; i++) q[1].push_back({1'b0, 8'h80 + 8'(i)});
        q[2].push_back({1'b1, 8'hC0}); q[2].push_back({1'b1, 8'hC1});
        drain(1000);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
        exp_q.push_back(8'hC0);
        for (int i = 16; i < 20; i++) exp_q.push_back(8'h80 + 8'(i));
        exp_q.push_back(8'hC1);
        check_log("t4_log", exp_q);

        // busy never rises: timeout, byte dropped, next requester served
        begin_test();
        drop_cnt = 1;
        q[0].push_back({1'b1, 8'h5A});
        q[3].push_back({1'b1, 8'h3C});
        drain(ST + 500);
        check("t5_dut_timeout_delay", 32'(d_to_cyc - d_first_tx), 32'(ST + 1));
        check("t5_model_timeout_delay", 32'(e_to_cyc - e_first_tx), 32'(ST + 1));
        exp_q = '{8'h5A, 8'h3C};
        check_log("t5_log", exp_q);

        // reset during WAIT_DONE, busy still high afterwards
        begin_test();
        u_len_fixed = 12;
        q[1].push_back({1'b1, 8'h71});
        q[2].push_back({1'b1, 8'h72});
        k = 0;
        while (k < 60 && !(m_inflight && m_rise >= 0)) begin
            cycle();
            k++;
        end
        check("t6_reach_wait_done", 32'(k < 60), 32'd1);
        rst_req = 1'b1;
        u_end = cyc + 8;
        busy_end = u_end;
        cycle();
        rst_req = 1'b0;
        cycle();
        check("t6_rst_transmit", 32'(bus.transmit), 32'd0);
        check("t6_rst_active", 32'(bus.active), 32'd0);
        check("t6_rst_tx_data", 32'(bus.TX_DATA), 32'd0);
        check("t6_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("t6_rst_ready", 32'(bus.req_ready), 32'd0);
        drain(300);
        check("t6_tx_count", 32'(d_tx_cnt), 32'd2);
        check("t6_accept_when_busy_falls", 32'(d_last_acc), 32'(busy_end));
        exp_q = '{8'h71, 8'h72};
        check_log("t6_log", exp_q);

        // random traffic with gated valids, UART glitches, drops and a mid-run reset
        begin_test();
        vprob = 70;
        glitch_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(99) < 6) begin
                r = $urandom_range(N - 1);
                len = ($urandom_range(9) == 0) ? 18 : $urandom_range(1, 4);
                if (q[r].size() < 24)
                    for (int i = 0; i < len; i++) q[r].push_back({(i == len - 1), 8'($urandom)});
            end
            if (c == 1000 || c == 2500) drop_cnt = 1;
            rst_req = (c == 3000);
            cycle();
        end
        rst_req = 1'b0;
        drain(2 * ST + 4000);
        check("rand_log_len", 32'(dlog.size()), 32'(mlog.size()));
        for (int i = 0; i < mlog.size() && i < dlog.size(); i++)
            check("rand_log_byte", 32'(dlog[i]), 32'(mlog[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
